adc_trigger_capture: RTL and testbench
======================================

// Module: adc_trigger_capture
//
// PURPOSE
//  Downstream of the AD9228 per-channel deserializer.
//  Takes 12-bit samples plus a one-cycle valid strobe, already in the clk domain.
//  Waits for an armed level-crossing or forced trigger, then captures a programmed
//  number of samples. Each sample is split into two bytes and stored in an internal
//  FIFO that the control board reads out 8 bits at a time.
//
// PARAMETERS
//  DATA_WIDTH  12    sample width; fixed at 12, since the byte packing depends on it
//  FIFO_DEPTH  2048  FIFO depth in bytes; must be a power of 2 and at least 4
//
// PORTS
//  clk             in   1   system clock; samples arrive synchronous to it
//  rst             in   1   asynchronous, active-high reset
//  sample_in       in   12  deserialized ADC word
//  sample_valid    in   1   one-cycle strobe; consecutive strobes at least 2 cycles apart
//  arm             in   1   one-cycle pulse; latches settings and enters ARMED
//  soft_clear      in   1   one-cycle pulse; flushes FIFO, goes to IDLE, clears flags
//  trig_force      in   1   level; triggers on the next valid sample while ARMED
//  threshold       in   12  rising-crossing level (unsigned)
//  capture_len     in   16  number of samples to capture after the trigger
//  fifo_rd_en      in   1   read one byte
//  fifo_dout       out  8   read data; registered, valid 1 cycle after fifo_rd_en
//  fifo_not_empty  out  1   byte count != 0
//  fifo_full       out  1   byte count == FIFO_DEPTH
//  armed           out  1   high in the ARMED state
//  capture_done    out  1   high in the DONE state
//  overflow        out  1   sticky; set when a sample is dropped because the FIFO is full
//
// BEHAVIOUR
//  - Reset values:
//    - State IDLE; FIFO emptied (pointers and count = 0).
//    - fifo_dout = 0; fifo_not_empty = 0; fifo_full = 0.
//    - armed = 0; capture_done = 0; overflow = 0.
//  - States:
//    - IDLE: on arm, go to ARMED.
//    - ARMED: waits for a trigger (below).
//    - CAPTURE: stores samples (below).
//    - DONE: holds until the next arm.
//  - Arm handling:
//    - arm latches threshold and capture_len and clears overflow.
//    - arm is accepted in IDLE, ARMED (re-latch) and DONE.
//    - arm is ignored in CAPTURE.
//    - The FIFO is not flushed by arm.
//  - Trigger (ARMED, on a sample_valid cycle), either of:
//    - trig_force = 1.
//    - Rising crossing: prev_sample < threshold and sample_in >= threshold.
//  - Crossing reference:
//    - prev_sample updates on every sample_valid, in every state.
//    - prev_sample resets to 0xFFF, so the first sample after reset cannot cross.
//  - Trigger actions:
//    - The trigger sample is capture sample #1.
//    - The remaining count is loaded with capture_len.
//    - If capture_len = 0: go straight to DONE and write nothing.
//    - Otherwise: go to CAPTURE.
//  - Capture (sample_valid at cycle t, with space for 2 bytes):
//    - t+1: write {sample[7:0]}.
//    - t+2: write {4'h0, sample[11:8]}.
//    - Remaining count is decremented.
//    - When the count reaches 0, DONE is entered after the t+2 write.
//  - Full FIFO:
//    - If fewer than 2 bytes are free at cycle t, the whole sample is dropped.
//    - overflow is set.
//    - The count still decrements, so the capture always terminates.
//    - No partial sample is ever stored.
//  - Read side:
//    - fifo_rd_en when empty is ignored; fifo_dout holds its value.
//    - Simultaneous read and write: both take effect and the count is unchanged.
//      Free space is judged from the count before the read.
//  - Flags:
//    - fifo_not_empty and fifo_full are derived from the registered count.
//    - Both update the cycle after a write or read.
//  - soft_clear:
//    - Takes priority over everything, including arm on the same cycle.
//    - Next cycle: state IDLE, FIFO empty, capture_done = 0, overflow = 0.
//    - Any pending byte-1 write is cancelled.
//  - Reset mid-capture has the same effect as soft_clear, but is asynchronous.
//  - Pointers wrap modulo FIFO_DEPTH; the count ranges 0..FIFO_DEPTH.
//
// CONFIGURATION
//  ADC_CAPTURE_TEST_PATTERN_EN
//  - Defined: sample_in is ignored and replaced by a 12-bit ramp.
//    - The ramp resets to 0 and increments on every sample_valid, wrapping 0xFFF -> 0x000.
//    - Trigger logic and FIFO writes use the ramp.
//  - Undefined: sample_in is used directly and no ramp logic is built.
//
// TESTING
//  - Trigger capture: arm, threshold = 0x800, capture_len = 3, samples 0x100, 0x900,
//    0xABC, 0x7FF.
//    -> Trigger on 0x900.
//    -> FIFO holds 00, 09, BC, 0A, FF, 07.
//    -> capture_done rises after the 6th write.
//  - No crossing: arm, threshold = 0x800, samples 0x900, 0x900 (no rising crossing).
//    -> Stays ARMED; FIFO stays empty.
//  - Forced trigger: trig_force = 1, arm, capture_len = 0, one sample.
//    -> DONE with no writes; fifo_not_empty = 0.
//  - Overflow: FIFO_DEPTH = 4, capture_len = 3, no reads.
//    -> 4 bytes stored; 3rd sample dropped; overflow = 1.
//    -> fifo_full = 1; DONE is still reached.
//  - Mid-capture clear: soft_clear during CAPTURE, after 1 byte written.
//    -> Next cycle: IDLE, FIFO empty, no byte-1 write follows.
//  - Read-back: read 2 bytes after scenario 1 -> fifo_dout = 0x00 then 0x09, each 1 cycle
//    after fifo_rd_en.
//    - With ADC_CAPTURE_TEST_PATTERN_EN: force-trigger capture of 2 samples -> 00 00 01 00.

Source files
------------

// File: rtl/adc_trigger_capture_if.sv
// Interface for adc_trigger_capture: sample stream, control and FIFO read port.
// The signal names match the original flat port list of the block.
interface adc_trigger_capture_if;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic        arm;
  logic        soft_clear;
  logic        trig_force;
  logic [11:0] threshold;
  logic [15:0] capture_len;
  logic        fifo_rd_en;
  logic [7:0]  fifo_dout;
  logic        fifo_not_empty;
  logic        fifo_full;
  logic        armed;
  logic        capture_done;
  logic        overflow;

  // Deserializer and control-board side
  modport master (
    output sample_in, sample_valid, arm, soft_clear, trig_force,
           threshold, capture_len, fifo_rd_en,
    input  fifo_dout, fifo_not_empty, fifo_full, armed, capture_done, overflow
  );

  // Capture block side
  modport slave (
    input  sample_in, sample_valid, arm, soft_clear, trig_force,
           threshold, capture_len, fifo_rd_en,
    output fifo_dout, fifo_not_empty, fifo_full, armed, capture_done, overflow
  );
endinterface

// File: rtl/adc_trigger_capture.sv
// adc_trigger_capture: waits for an armed rising level crossing (or a forced
// trigger) on the deserialized 12-bit ADC stream, then stores capture_len
// samples as two bytes each (low byte, then {4'h0, high nibble}) in a byte FIFO.
// Optional build macro: ADC_CAPTURE_TEST_PATTERN_EN replaces sample_in with an
// internal 12-bit ramp that advances on every sample_valid.
module adc_trigger_capture #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH = 2048
) (
  input  logic                 clk,
  input  logic                 rst,
  adc_trigger_capture_if.slave bus
);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] smp;
  logic [DATA_WIDTH-1:0] thr_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [15:0]           len_q;
  logic [15:0]           remain_q;
  logic                  wr_lo_q;
  logic                  wr_hi_q;
  logic                  armed_q;
  logic                  done_q;
  logic                  ovf_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [7:0]            dout_q;
  logic [7:0]            mem_q [FIFO_DEPTH];
  logic [7:0]            wr_byte;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  trig_hit;
  logic                  space_ok;
  logic                  take_sample;

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
  logic [DATA_WIDTH-1:0] ramp_q;

  // Test ramp: advances once per incoming strobe, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp_q <= '0;
    end else if (bus.sample_valid) begin
      ramp_q <= ramp_q + 1'b1;
    end
  end

  always_comb smp = ramp_q;
`else
  always_comb smp = bus.sample_in;
`endif

  // Trigger detection, space check and write-byte selection
  always_comb begin
    rd_fire  = bus.fifo_rd_en && (count_q != '0);
    wr_fire  = wr_lo_q || wr_hi_q;
    trig_hit = bus.sample_valid &&
               (bus.trig_force || ((prev_q < thr_q) && (smp >= thr_q)));
    // A high byte still in flight already owns a slot, so it counts as used
    space_ok = (32'(count_q) + 32'(wr_hi_q) + 32'd2) <= FIFO_DEPTH;
    wr_byte  = wr_lo_q ? hold_q[7:0] : {4'h0, hold_q[DATA_WIDTH-1:8]};
    take_sample = 1'b0;
    if (!bus.soft_clear) begin
      case (state_q)
        S_ARMED:   take_sample = !bus.arm && trig_hit && (len_q != '0);
        S_CAPTURE: take_sample = bus.sample_valid && (remain_q != '0);
        default:   take_sample = 1'b0;
      endcase
    end
  end

  // Control FSM: arming, trigger, sample counting, write sequencing, flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      thr_q    <= '0;
      len_q    <= '0;
      remain_q <= '0;
      prev_q   <= '1;
      hold_q   <= '0;
      wr_lo_q  <= 1'b0;
      wr_hi_q  <= 1'b0;
      armed_q  <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (bus.sample_valid) begin
        prev_q <= smp;
      end
      wr_hi_q <= wr_lo_q && !bus.soft_clear;
      wr_lo_q <= 1'b0;
      if (take_sample) begin
        if (space_ok) begin
          hold_q  <= smp;
          wr_lo_q <= 1'b1;
        end else begin
          ovf_q <= 1'b1;
        end
      end
      if (bus.soft_clear) begin
        state_q <= S_IDLE;
        armed_q <= 1'b0;
        done_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end else if (bus.arm && (state_q != S_CAPTURE)) begin
        // Arm beats a same-cycle trigger while already armed
        thr_q   <= bus.threshold;
        len_q   <= bus.capture_len;
        ovf_q   <= 1'b0;
        state_q <= S_ARMED;
        armed_q <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          S_ARMED: begin
            if (trig_hit) begin
              armed_q <= 1'b0;
              if (len_q == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q  <= S_CAPTURE;
                remain_q <= len_q - 16'd1;
              end
            end
          end
          S_CAPTURE: begin
            // Last sample counted: finish once its low byte is no longer pending,
            // i.e. on the high-byte write cycle (or right after a dropped sample)
            if (remain_q == '0) begin
              if (!wr_lo_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end else if (take_sample) begin
              remain_q <= remain_q - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // FIFO pointers, occupancy count and registered read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else if (bus.soft_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        dout_q   <= mem_q[rd_ptr_q];
      end
      case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage array
  always_ff @(posedge clk) begin
    if (wr_fire && !bus.soft_clear) begin
      mem_q[wr_ptr_q] <= wr_byte;
    end
  end

  assign bus.fifo_dout      = dout_q;
  assign bus.fifo_not_empty = (count_q != '0);
  assign bus.fifo_full      = (count_q == FULL_CNT);
  assign bus.armed          = armed_q;
  assign bus.capture_done   = done_q;
  assign bus.overflow       = ovf_q;
endmodule

// File: tb/tb_adc_trigger_capture.sv
// Bench for adc_trigger_capture: a default-depth and a 4-byte-deep instance share
// one stimulus stream; a transaction-level model (byte queue plus scheduled
// byte arrivals) predicts every output of both instances each cycle.
module tb_adc_trigger_capture;
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAPT = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        arm = 1'b0;
  logic        soft_clear = 1'b0;
  logic        trig_force = 1'b0;
  logic [11:0] threshold = '0;
  logic [15:0] capture_len = '0;
  logic        fifo_rd_en = 1'b0;
  bit          chk_en = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  adc_trigger_capture_if bus_big ();
  adc_trigger_capture_if bus_small ();

  assign bus_big.sample_in      = sample_in;
  assign bus_big.sample_valid   = sample_valid;
  assign bus_big.arm            = arm;
  assign bus_big.soft_clear     = soft_clear;
  assign bus_big.trig_force     = trig_force;
  assign bus_big.threshold      = threshold;
  assign bus_big.capture_len    = capture_len;
  assign bus_big.fifo_rd_en     = fifo_rd_en;
  assign bus_small.sample_in    = sample_in;
  assign bus_small.sample_valid = sample_valid;
  assign bus_small.arm          = arm;
  assign bus_small.soft_clear   = soft_clear;
  assign bus_small.trig_force   = trig_force;
  assign bus_small.threshold    = threshold;
  assign bus_small.capture_len  = capture_len;
  assign bus_small.fifo_rd_en   = fifo_rd_en;

  adc_trigger_capture #(.FIFO_DEPTH(2048)) u_big (.clk(clk), .rst(rst), .bus(bus_big));
  adc_trigger_capture #(.FIFO_DEPTH(4))    u_small (.clk(clk), .rst(rst), .bus(bus_small));

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  string       nm [2] = '{"big", "small"};
  int unsigned depth [2] = '{2048, 4};
  int          mode [2];
  logic [11:0] m_thr [2];
  logic [11:0] m_prev [2];
  logic [11:0] m_ramp [2];
  int unsigned m_len [2];
  int unsigned m_left [2];
  bit          m_ovf [2];
  logic [7:0]  m_dout [2];
  logic [7:0]  fq [2][$];
  longint      pend_due [2][$];
  logic [7:0]  pend_val [2][$];
  longint      finish_at [2];
  longint      cyc = 0;

  task automatic model_reset(input int d);
    mode[d] = M_IDLE;
    m_thr[d] = '0;
    m_prev[d] = 12'hFFF;
    m_ramp[d] = '0;
    m_len[d] = 0;
    m_left[d] = 0;
    m_ovf[d] = 1'b0;
    m_dout[d] = '0;
    fq[d].delete();
    pend_due[d].delete();
    pend_val[d].delete();
    finish_at[d] = -1;
  endtask

  task automatic model_edge(input int d);
    logic [11:0] s;
    bit take;
    int unsigned used;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    s = m_ramp[d];
`else
    s = sample_in;
`endif
    take = 1'b0;
    if (soft_clear) begin
      fq[d].delete();
      pend_due[d].delete();
      pend_val[d].delete();
      mode[d] = M_IDLE;
      m_ovf[d] = 1'b0;
      finish_at[d] = -1;
    end else begin
      used = fq[d].size() + pend_due[d].size();
      if (fifo_rd_en && fq[d].size() != 0) m_dout[d] = fq[d].pop_front();
      while (pend_due[d].size() != 0 && pend_due[d][0] == cyc) begin
        fq[d].push_back(pend_val[d].pop_front());
        void'(pend_due[d].pop_front());
      end
      if (arm && mode[d] != M_CAPT) begin
        m_thr[d] = threshold;
        m_len[d] = capture_len;
        m_ovf[d] = 1'b0;
        mode[d] = M_ARMED;
      end else if (mode[d] == M_ARMED && sample_valid &&
                   (trig_force || (m_prev[d] < m_thr[d] && s >= m_thr[d]))) begin
        if (m_len[d] == 0) mode[d] = M_DONE;
        else begin
          mode[d] = M_CAPT;
          m_left[d] = m_len[d];
          take = 1'b1;
        end
      end else if (mode[d] == M_CAPT && sample_valid && m_left[d] != 0) begin
        take = 1'b1;
      end
      if (take) begin
        m_left[d]--;
        if (used + 2 <= depth[d]) begin
          pend_due[d].push_back(cyc + 1);
          pend_val[d].push_back(s[7:0]);
          pend_due[d].push_back(cyc + 2);
          pend_val[d].push_back({4'h0, s[11:8]});
          if (m_left[d] == 0) finish_at[d] = cyc + 2;
        end else begin
          m_ovf[d] = 1'b1;
          if (m_left[d] == 0) finish_at[d] = cyc + 1;
        end
      end
      if (mode[d] == M_CAPT && finish_at[d] == cyc) begin
        mode[d] = M_DONE;
        finish_at[d] = -1;
      end
    end
    if (sample_valid) begin
      m_prev[d] = s;
      m_ramp[d] = m_ramp[d] + 12'd1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
      cyc = 0;
    end else begin
      model_edge(0);
      model_edge(1);
      cyc = cyc + 1;
    end
  end

  task automatic compare_dut(input int d, input logic [7:0] dout, input logic ne,
                             input logic full, input logic armed_o,
                             input logic done_o, input logic ovf_o);
    check_val({nm[d], ".fifo_dout"}, 32'(dout), 32'(m_dout[d]));
    check_val({nm[d], ".fifo_not_empty"}, 32'(ne), 32'(fq[d].size() != 0));
    check_val({nm[d], ".fifo_full"}, 32'(full), 32'(fq[d].size() == depth[d]));
    check_val({nm[d], ".armed"}, 32'(armed_o), 32'(mode[d] == M_ARMED));
    check_val({nm[d], ".capture_done"}, 32'(done_o), 32'(mode[d] == M_DONE));
    check_val({nm[d], ".overflow"}, 32'(ovf_o), 32'(m_ovf[d]));
  endtask

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      compare_dut(0, bus_big.fifo_dout, bus_big.fifo_not_empty, bus_big.fifo_full,
                  bus_big.armed, bus_big.capture_done, bus_big.overflow);
      compare_dut(1, bus_small.fifo_dout, bus_small.fifo_not_empty, bus_small.fifo_full,
                  bus_small.armed, bus_small.capture_done, bus_small.overflow);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [11:0] s);
    sample_in = s;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_arm(input logic [11:0] thr, input logic [15:0] len);
    threshold = thr;
    capture_len = len;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_clear();
    soft_clear = 1'b1;
    @(negedge clk);
    soft_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_one(output logic [7:0] b);
    fifo_rd_en = 1'b1;
    @(negedge clk);
    fifo_rd_en = 1'b0;
    b = bus_big.fifo_dout;
  endtask

  initial begin
    logic [7:0] b;
    bit last_vld;
`ifndef ADC_CAPTURE_TEST_PATTERN_EN
    logic [7:0] s1_bytes [6] = '{8'h00, 8'h09, 8'hBC, 8'h0A, 8'hFF, 8'h07};
`else
    logic [7:0] pat_bytes [4] = '{8'h00, 8'h00, 8'h01, 8'h00};
`endif
    // Reset values
    idle(3);
    check_val("rst.fifo_dout", 32'(bus_big.fifo_dout), 32'h0);
    check_val("rst.fifo_not_empty", 32'(bus_big.fifo_not_empty), 32'h0);
    check_val("rst.fifo_full", 32'(bus_small.fifo_full), 32'h0);
    check_val("rst.armed", 32'(bus_big.armed), 32'h0);
    check_val("rst.capture_done", 32'(bus_big.capture_done), 32'h0);
    check_val("rst.overflow", 32'(bus_small.overflow), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(1);

    // Trigger capture; the 4-deep instance doubles as the overflow scenario
    do_arm(12'h800, 16'd3);
    send(12'h100);
    send(12'h900);
    send(12'hABC);
    send(12'h7FF);
    idle(4);
`ifndef ADC_CAPTURE_TEST_PATTERN_EN
    check_val("s1.big_done", 32'(bus_big.capture_done), 32'h1);
    check_val("s1.small_overflow", 32'(bus_small.overflow), 32'h1);
    check_val("s1.small_full", 32'(bus_small.fifo_full), 32'h1);
    check_val("s1.small_done", 32'(bus_small.capture_done), 32'h1);
    for (int i = 0; i < 6; i++) begin
      read_one(b);
      check_val($sformatf("s1.readback%0d", i), 32'(b), 32'(s1_bytes[i]));
    end
`endif
    idle(2);

    // No rising crossing: stays armed, nothing written
    do_clear();
    send(12'h900);
    do_arm(12'h800, 16'd3);
    send(12'h900);
    send(12'h900);
`ifndef ADC_CAPTURE_TEST_PATTERN_EN
    check_val("s2.armed", 32'(bus_big.armed), 32'h1);
    check_val("s2.empty", 32'(bus_big.fifo_not_empty), 32'h0);
`endif

    // Forced trigger with zero length
    do_clear();
    trig_force = 1'b1;
    do_arm(12'h800, 16'd0);
    send(12'h123);
    trig_force = 1'b0;
    check_val("s3.done", 32'(bus_big.capture_done), 32'h1);
    check_val("s3.empty", 32'(bus_big.fifo_not_empty), 32'h0);

    // soft_clear after the first byte of a sample is written
    do_clear();
    trig_force = 1'b1;
    do_arm(12'h800, 16'd5);
    sample_in = 12'h5A5;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    trig_force = 1'b0;
    @(negedge clk);
    check_val("s5.one_byte", 32'(bus_big.fifo_not_empty), 32'h1);
    soft_clear = 1'b1;
    @(negedge clk);
    soft_clear = 1'b0;
    check_val("s5.empty", 32'(bus_big.fifo_not_empty), 32'h0);
    check_val("s5.not_armed", 32'(bus_big.armed), 32'h0);
    check_val("s5.not_done", 32'(bus_big.capture_done), 32'h0);
    @(negedge clk);
    check_val("s5.no_byte1", 32'(bus_big.fifo_not_empty), 32'h0);

    // Asynchronous reset in the middle of a capture
    trig_force = 1'b1;
    do_arm(12'h800, 16'd4);
    send(12'h321);
    send(12'h654);
    trig_force = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("arst.fifo_not_empty", 32'(bus_big.fifo_not_empty), 32'h0);
    check_val("arst.fifo_full", 32'(bus_small.fifo_full), 32'h0);
    check_val("arst.armed", 32'(bus_big.armed), 32'h0);
    check_val("arst.capture_done", 32'(bus_big.capture_done), 32'h0);
    check_val("arst.overflow", 32'(bus_small.overflow), 32'h0);
    check_val("arst.fifo_dout", 32'(bus_big.fifo_dout), 32'h0);
    idle(2);
    rst = 1'b0;
    idle(1);

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    // Ramp source: forced capture of two samples right after reset
    trig_force = 1'b1;
    do_arm(12'h000, 16'd2);
    send(12'hFFF);
    send(12'hFFF);
    trig_force = 1'b0;
    idle(3);
    check_val("pat.done", 32'(bus_big.capture_done), 32'h1);
    for (int i = 0; i < 4; i++) begin
      read_one(b);
      check_val($sformatf("pat.readback%0d", i), 32'(b), 32'(pat_bytes[i]));
    end
`endif

    // Randomized traffic against the model
    last_vld = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      sample_valid = !last_vld && ($urandom_range(0, 2) == 0);
      sample_in    = 12'($urandom_range(0, 4095));
      arm          = ($urandom_range(0, 40) == 0);
      soft_clear   = ($urandom_range(0, 150) == 0);
      trig_force   = ($urandom_range(0, 10) == 0);
      threshold    = 12'($urandom_range(0, 4095));
      capture_len  = 16'($urandom_range(0, 6));
      fifo_rd_en   = ($urandom_range(0, 3) == 0);
      last_vld     = sample_valid;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    arm = 1'b0;
    soft_clear = 1'b0;
    trig_force = 1'b0;
    fifo_rd_en = 1'b0;
    idle(4);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
